multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the 2-bit `aluOp` consumed by the ALU control decoder and all mux selects and write enables of the shared ALU/memory datapath. Memory accesses use a `memReady` handshake so the FSM can stall on slow memory.

## Interface
Parameters: none (opcode and `aluOp` encodings are fixed below).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `opcode` input 6: instruction[31:26] from the instruction register; stable from DECODE onward.
- `memReady` input 1: memory access completes in the current cycle.
- `aluOp` output 2: 00 add, 01 sub, 10 R-type (use funct), 11 or.
- `aluSrcA` output 1: 0 = PC, 1 = register A.
- `aluSrcB` output 2: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = immediate<<2.
- `zeroExt` output 1: 1 = immediate zero-extended (ori); 0 = sign-extended.
- `pcSrc` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcWrite` output 1: unconditional PC write.
- `branchEq` output 1: PC write if ALU zero.
- `branchNe` output 1: PC write if not zero.
- `iorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memRead` output 1: memory read request.
- `memWrite` output 1: memory write request.
- `irWrite` output 1: instruction register load.
- `regDst` output 1: 1 = rd, 0 = rt.
- `memToReg` output 1: 1 = MDR, 0 = ALUOut.
- `regWrite` output 1: register file write.
- `illegalOp` output 1: unknown opcode decoded.
- `state` output 4: current state, for debug.

## Operation
Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, j 000010.

States and encodings, with the outputs each state asserts. Any output not listed is 0.
- FETCH (0): `memRead`=1, `iorD`=0, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=00, `pcSrc`=00, `irWrite`=`pcWrite`=`memReady`.
  - Stays in FETCH until `memReady`, then goes to DECODE.
- DECODE (1): `aluSrcA`=0, `aluSrcB`=11, `aluOp`=00.
  - lw or sw -> MEMADR.
  - R-type -> EXECUTE.
  - beq or bne -> BRANCH.
  - addi -> ADDIEX.
  - ori -> ORIEX.
  - j -> JUMP.
  - Any other opcode: `illegalOp`=1 this cycle, -> FETCH.
- MEMADR (2): `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD (3): `iorD`=1, `memRead`=1. Holds until `memReady`, then -> MEMWB.
- MEMWB (4): `regDst`=0, `memToReg`=1, `regWrite`=1. -> FETCH.
- MEMWR (5): `iorD`=1, `memWrite`=1. Holds until `memReady`, then -> FETCH.
- EXECUTE (6): `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10. -> ALUWB.
- ALUWB (7): `regDst`=1, `memToReg`=0, `regWrite`=1. -> FETCH.
- BRANCH (8): `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcSrc`=01, `branchEq`=(opcode==beq), `branchNe`=(opcode==bne). -> FETCH.
- ADDIEX (9): `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00, `zeroExt`=0. -> IMMWB.
- ORIEX (10): `aluSrcA`=1, `aluSrcB`=10, `aluOp`=11, `zeroExt`=1. -> IMMWB.
- IMMWB (11): `regDst`=0, `memToReg`=0, `regWrite`=1. -> FETCH.
- JUMP (12): `pcSrc`=10, `pcWrite`=1. -> FETCH.
- Codes 13-15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.

General rules:
- The state register is the only storage. Outputs are decoded combinationally from state, plus `memReady` in FETCH and `opcode` in DECODE/BRANCH.
- At most one of `memRead` and `memWrite` is high in any cycle.
- At most one of `pcWrite`, `branchEq` and `branchNe` is high in any cycle.

## Timing
- Reset: while `reset`=1, `state`=0 (FETCH) and every output is forced to 0, including `memRead`. FETCH outputs appear combinationally once `reset` falls.
- Reset asserted in any state, including mid-stall in MEMRD or MEMWR, aborts the instruction immediately. No `regWrite` or `memWrite` is issued afterwards.
- Cycles per instruction with `memReady` constantly 1:
  - lw 5; sw 4; R-type, addi, ori 4; beq, bne, j 3; illegal 2.
- Each cycle with `memReady`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- The request (`memRead`/`memWrite`) and `iorD` stay asserted and stable throughout a stall.
- `memReady` is ignored in every other state.
- `irWrite` and `pcWrite` pulse in FETCH only in the cycle where `memReady`=1, so exactly one IR load and one PC+4 update occur per instruction.

## Test plan
- Reset then R-type sub (opcode 000000), `memReady`=1: states 0,1,6,7,0. `aluOp`=10 in EXECUTE; `regWrite`=1 with `regDst`=1 in ALUWB; `irWrite` pulses once.
- lw with `memReady` low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. `iorD`=`memRead`=1 held all three MEMRD cycles; `memToReg`=`regWrite`=1 in MEMWB.
- sw, then beq, then bne: sw gives states 0,1,2,5,0 with `memWrite`=1 only in MEMWR. BRANCH has `aluOp`=01, `pcSrc`=01, with `branchEq`=1 for 000100 and `branchNe`=1 for 000101.
- addi, ori, j: `aluOp` is 00 in ADDIEX and 11 in ORIEX; `zeroExt`=1 only in ORIEX; both reach IMMWB with `regDst`=0. j: states 0,1,12,0 with `pcSrc`=10, `pcWrite`=1.
- Opcode 111111: `illegalOp`=1 for the single DECODE cycle, no write enables, next state FETCH.
- `memReady`=0 for 3 cycles in FETCH, and `reset` asserted mid-MEMRD stall: FETCH holds with `irWrite`=`pcWrite`=0 until ready. After reset, `state`=0 asynchronously, all outputs are 0, and no `regWrite` is issued.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// decodes every datapath mux select and write enable from the current state.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       memReady,
   output logic [1:0] aluOp,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic       zeroExt,
   output logic [1:0] pcSrc,
   output logic       pcWrite,
   output logic       branchEq,
   output logic       branchNe,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       regWrite,
   output logic       illegalOp,
   output logic [3:0] state
);

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpJ     = 6'b000010;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StAddiEx  = 4'd9,
      StOriEx   = 4'd10,
      StImmWb   = 4'd11,
      StJump    = 4'd12
   } state_e;

   state_e r_state;
   state_e w_next_state;

   assign state = r_state;

   // State register; reset aborts any instruction, including a memory stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; memReady only matters in the three memory-access states.
   always_comb begin
      w_next_state = StFetch;
      case (r_state)
         StFetch:   w_next_state = memReady ? StDecode : StFetch;
         StDecode: begin
            case (opcode)
               OpLw, OpSw:   w_next_state = StMemAdr;
               OpRType:      w_next_state = StExecute;
               OpBeq, OpBne: w_next_state = StBranch;
               OpAddi:       w_next_state = StAddiEx;
               OpOri:        w_next_state = StOriEx;
               OpJ:          w_next_state = StJump;
               default:      w_next_state = StFetch;
            endcase
         end
         StMemAdr:  w_next_state = (opcode == OpLw) ? StMemRd : StMemWr;
         StMemRd:   w_next_state = memReady ? StMemWb : StMemRd;
         StMemWb:   w_next_state = StFetch;
         StMemWr:   w_next_state = memReady ? StFetch : StMemWr;
         StExecute: w_next_state = StAluWb;
         StAluWb:   w_next_state = StFetch;
         StBranch:  w_next_state = StFetch;
         StAddiEx:  w_next_state = StImmWb;
         StOriEx:   w_next_state = StImmWb;
         StImmWb:   w_next_state = StFetch;
         StJump:    w_next_state = StFetch;
         default:   w_next_state = StFetch;
      endcase
   end

   // Output decode; everything is held low while reset is asserted.
   always_comb begin
      aluOp     = 2'b00;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'b00;
      zeroExt   = 1'b0;
      pcSrc     = 2'b00;
      pcWrite   = 1'b0;
      branchEq  = 1'b0;
      branchNe  = 1'b0;
      iorD      = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      regDst    = 1'b0;
      memToReg  = 1'b0;
      regWrite  = 1'b0;
      illegalOp = 1'b0;
      if (!reset) begin
         case (r_state)
            StFetch: begin
               memRead = 1'b1;
               aluSrcB = 2'b01;
               // IR load and PC+4 only on the cycle the fetch completes
               irWrite = memReady;
               pcWrite = memReady;
            end
            StDecode: begin
               aluSrcB = 2'b11;
               case (opcode)
                  OpRType, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpOri, OpJ: illegalOp = 1'b0;
                  default:                                              illegalOp = 1'b1;
               endcase
            end
            StMemAdr: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
            end
            StMemRd: begin
               iorD    = 1'b1;
               memRead = 1'b1;
            end
            StMemWb: begin
               memToReg = 1'b1;
               regWrite = 1'b1;
            end
            StMemWr: begin
               iorD     = 1'b1;
               memWrite = 1'b1;
            end
            StExecute: begin
               aluSrcA = 1'b1;
               aluOp   = 2'b10;
            end
            StAluWb: begin
               regDst   = 1'b1;
               regWrite = 1'b1;
            end
            StBranch: begin
               aluSrcA  = 1'b1;
               aluOp    = 2'b01;
               pcSrc    = 2'b01;
               branchEq = (opcode == OpBeq);
               branchNe = (opcode == OpBne);
            end
            StAddiEx: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
            end
            StOriEx: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               aluOp   = 2'b11;
               zeroExt = 1'b1;
            end
            StImmWb: begin
               regWrite = 1'b1;
            end
            StJump: begin
               pcSrc   = 2'b10;
               pcWrite = 1'b1;
            end
            default: begin
               aluOp = 2'b00;
            end
         endcase
      end
   end

endmodule
